ysyx_22040759_mem_arbiter: RTL and testbench

Arbitrates the single AXI-bridge memory port between the instruction cache (read-only refill) and the data cache (writeback, refill, flush writeback). Sits between the two caches' `*_ram_*` request interfaces and the AXI master bridge. Grants are round-robin. A dcache writeback is followed atomically by its refill read. One downstream request is outstanding at a time.

---
 rtl/ysyx_22040759_mem_arbiter_pkg.sv | 23 ++
 rtl/ysyx_22040759_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_ysyx_22040759_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-AXI-bridge memory arbiter.
package ysyx_22040759_mem_arbiter_pkg;

    // One-hot arbiter states. Each state owns one bit so the decode of
    // "granted to X" is a single flop output.
    localparam logic [3:0] ARB_IDLE   = 4'b0001;
    localparam logic [3:0] ARB_GNT_I  = 4'b0010;
    localparam logic [3:0] ARB_GNT_D  = 4'b0100;
    localparam logic [3:0] ARB_D_HOLD = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE   = ARB_IDLE,
        S_GNT_I  = ARB_GNT_I,
        S_GNT_D  = ARB_GNT_D,
        S_D_HOLD = ARB_D_HOLD
    } arb_state_e;

    // Round-robin tie break: the side that was not served last wins.
    function automatic arb_state_e tie_winner(input logic last_d);
        return last_d ? S_GNT_I : S_GNT_D;
    endfunction

endpackage

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Round-robin arbiter sharing the single AXI-bridge port between the
// icache (refill reads) and the dcache (writebacks, refills, flushes).
// A dcache write keeps the grant through D_HOLD so its refill read follows
// without the icache slipping in. Exactly one bridge request in flight.
module ysyx_22040759_mem_arbiter
    import ysyx_22040759_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    // icache side
    input  logic              icache_ram_valid,
    input  logic [ADDR_W-1:0] icache_ram_addr,
    input  logic [2:0]        icache_ram_size,
    output logic              icache_ram_ready,
    output logic [DATA_W-1:0] icache_ram_data_read,
    // dcache side
    input  logic              dcache_ram_valid,
    input  logic              dcache_ram_req,
    input  logic [ADDR_W-1:0] dcache_ram_addr,
    input  logic [DATA_W-1:0] dcache_ram_data_write,
    input  logic [2:0]        dcache_ram_size,
    output logic              dcache_ram_ready,
    output logic [DATA_W-1:0] dcache_ram_data_read,
    // bridge side
    output logic              arb_axi_valid,
    output logic              arb_axi_req,
    output logic [ADDR_W-1:0] arb_axi_addr,
    output logic [DATA_W-1:0] arb_axi_data_write,
    output logic [2:0]        arb_axi_size,
    input  logic              axi_arb_ready,
    input  logic [DATA_W-1:0] axi_arb_data_read,
    output logic              arb_busy
);

    arb_state_e state_q, state_d;
    logic       last_d_q, last_d_d;

    // State and round-robin history registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Next-state logic plus the inline grant mux. Bridge fields are only
    // non-zero while a grant is active; a bridge ready outside a grant
    // state falls through the default and is ignored.
    always_comb begin
        state_d              = state_q;
        last_d_d             = last_d_q;
        arb_axi_valid        = 1'b0;
        arb_axi_req          = 1'b0;
        arb_axi_addr         = '0;
        arb_axi_data_write   = '0;
        arb_axi_size         = 3'd0;
        icache_ram_ready     = 1'b0;
        dcache_ram_ready     = 1'b0;
        icache_ram_data_read = '0;
        dcache_ram_data_read = '0;

        case (state_q)
            S_IDLE: begin
                if (icache_ram_valid && dcache_ram_valid) begin
                    state_d = tie_winner(last_d_q);
                end else if (dcache_ram_valid) begin
                    state_d = S_GNT_D;
                end else if (icache_ram_valid) begin
                    state_d = S_GNT_I;
                end
            end

            S_GNT_I: begin
                // Held until the bridge answers, even if icache drops valid.
                arb_axi_valid        = 1'b1;
                arb_axi_addr         = icache_ram_addr;
                arb_axi_size         = icache_ram_size;
                icache_ram_data_read = axi_arb_data_read;
                dcache_ram_data_read = axi_arb_data_read;
                if (axi_arb_ready) begin
                    icache_ram_ready = 1'b1;
                    last_d_d         = 1'b0;
                    state_d          = S_IDLE;
                end
            end

            S_GNT_D: begin
                arb_axi_valid        = 1'b1;
                arb_axi_req          = dcache_ram_req;
                arb_axi_addr         = dcache_ram_addr;
                arb_axi_data_write   = dcache_ram_data_write;
                arb_axi_size         = dcache_ram_size;
                icache_ram_data_read = axi_arb_data_read;
                dcache_ram_data_read = axi_arb_data_read;
                if (axi_arb_ready) begin
                    dcache_ram_ready = 1'b1;
                    last_d_d         = 1'b1;
                    // A completed write keeps the port for the follow-up refill.
                    state_d          = dcache_ram_req ? S_D_HOLD : S_IDLE;
                end
            end

            S_D_HOLD: begin
                // One idle bus cycle; dcache keeps priority if it asks again.
                state_d = dcache_ram_valid ? S_GNT_D : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign arb_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
module tb_ysyx_22040759_mem_arbiter;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_GI   = 4'b0010;
    localparam logic [3:0] ST_GD   = 4'b0100;
    localparam logic [3:0] ST_HOLD = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_ram_valid;
    logic [31:0] icache_ram_addr;
    logic [2:0]  icache_ram_size;
    logic        icache_ram_ready;
    logic [63:0] icache_ram_data_read;
    logic        dcache_ram_valid;
    logic        dcache_ram_req;
    logic [31:0] dcache_ram_addr;
    logic [63:0] dcache_ram_data_write;
    logic [2:0]  dcache_ram_size;
    logic        dcache_ram_ready;
    logic [63:0] dcache_ram_data_read;
    logic        arb_axi_valid;
    logic        arb_axi_req;
    logic [31:0] arb_axi_addr;
    logic [63:0] arb_axi_data_write;
    logic [2:0]  arb_axi_size;
    logic        axi_arb_ready;
    logic [63:0] axi_arb_data_read;
    logic        arb_busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ysyx_22040759_mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .icache_ram_valid     (icache_ram_valid),
        .icache_ram_addr      (icache_ram_addr),
        .icache_ram_size      (icache_ram_size),
        .icache_ram_ready     (icache_ram_ready),
        .icache_ram_data_read (icache_ram_data_read),
        .dcache_ram_valid     (dcache_ram_valid),
        .dcache_ram_req       (dcache_ram_req),
        .dcache_ram_addr      (dcache_ram_addr),
        .dcache_ram_data_write(dcache_ram_data_write),
        .dcache_ram_size      (dcache_ram_size),
        .dcache_ram_ready     (dcache_ram_ready),
        .dcache_ram_data_read (dcache_ram_data_read),
        .arb_axi_valid        (arb_axi_valid),
        .arb_axi_req          (arb_axi_req),
        .arb_axi_addr         (arb_axi_addr),
        .arb_axi_data_write   (arb_axi_data_write),
        .arb_axi_size         (arb_axi_size),
        .axi_arb_ready        (axi_arb_ready),
        .axi_arb_data_read    (axi_arb_data_read),
        .arb_busy             (arb_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs change here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".state"}, 64'(dut.state_q), 64'(ST_IDLE));
        chk({tag, ".valid"}, 64'(arb_axi_valid), 64'd0);
        chk({tag, ".busy"},  64'(arb_busy), 64'd0);
        chk({tag, ".fields"}, {arb_axi_addr, 29'd0, arb_axi_req, arb_axi_size}, 64'd0);
        chk({tag, ".wdata"}, arb_axi_data_write, 64'd0);
        chk({tag, ".rdy"},   64'({icache_ram_ready, dcache_ram_ready}), 64'd0);
        chk({tag, ".irdata"}, icache_ram_data_read, 64'd0);
        chk({tag, ".drdata"}, dcache_ram_data_read, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        icache_ram_valid = 0; icache_ram_addr = 0; icache_ram_size = 0;
        dcache_ram_valid = 0; dcache_ram_req = 0; dcache_ram_addr = 0;
        dcache_ram_data_write = 0; dcache_ram_size = 0;
        axi_arb_ready = 0; axi_arb_data_read = 64'h1111_2222_3333_4444;

        // ---- reset state (bridge data non-zero must not leak through)
        do_reset();
        settle();
        chk_idle_outs("rst");
        chk("rst.last_d", 64'(dut.last_d_q), 64'd0);

        // ---- icache alone, bridge answers 3 cycles after valid
        icache_ram_valid = 1; icache_ram_addr = 32'h8000_0040; icache_ram_size = 3'd3;
        settle();
        chk("i1.lat0", 64'(arb_axi_valid), 64'd0);
        cyc(); settle();
        chk("i1.valid", 64'(arb_axi_valid), 64'd1);
        chk("i1.addr",  64'(arb_axi_addr), 64'h8000_0040);
        chk("i1.req",   64'(arb_axi_req), 64'd0);
        chk("i1.size",  64'(arb_axi_size), 64'd3);
        chk("i1.busy",  64'(arb_busy), 64'd1);
        cyc(); settle();
        chk("i1.wait1", 64'(icache_ram_ready), 64'd0);
        cyc(); settle();
        chk("i1.wait2", 64'(icache_ram_ready), 64'd0);
        cyc();
        axi_arb_ready = 1; axi_arb_data_read = 64'hCAFE_F00D_1234_5678;
        settle();
        chk("i1.irdy",  64'(icache_ram_ready), 64'd1);
        chk("i1.drdy",  64'(dcache_ram_ready), 64'd0);
        chk("i1.data",  icache_ram_data_read, 64'hCAFE_F00D_1234_5678);
        cyc();
        axi_arb_ready = 0; icache_ram_valid = 0;
        settle();
        chk("i1.done_st", 64'(dut.state_q), 64'(ST_IDLE));
        chk("i1.once",    64'(icache_ram_ready), 64'd0);
        chk("i1.vlow",    64'(arb_axi_valid), 64'd0);

        // ---- tie after reset: dcache first, then icache
        do_reset();
        icache_ram_valid = 1; icache_ram_addr = 32'h8000_0100; icache_ram_size = 3'd3;
        dcache_ram_valid = 1; dcache_ram_req = 0; dcache_ram_addr = 32'h8000_3000;
        dcache_ram_size = 3'd3;
        cyc(); settle();
        chk("tie.st1",  64'(dut.state_q), 64'(ST_GD));
        chk("tie.addr1", 64'(arb_axi_addr), 64'h8000_3000);
        axi_arb_ready = 1; axi_arb_data_read = 64'hAAAA_0000_0000_0001;
        settle();
        chk("tie.drdy", 64'(dcache_ram_ready), 64'd1);
        chk("tie.irdy0", 64'(icache_ram_ready), 64'd0);
        chk("tie.ddata", dcache_ram_data_read, 64'hAAAA_0000_0000_0001);
        cyc();
        axi_arb_ready = 0;
        settle();
        chk("tie.gap", 64'(arb_axi_valid), 64'd0);
        cyc(); settle();
        chk("tie.st2",  64'(dut.state_q), 64'(ST_GI));
        chk("tie.addr2", 64'(arb_axi_addr), 64'h8000_0100);
        axi_arb_ready = 1;
        settle();
        chk("tie.irdy", 64'(icache_ram_ready), 64'd1);
        chk("tie.drdy0", 64'(dcache_ram_ready), 64'd0);
        cyc();
        axi_arb_ready = 0; icache_ram_valid = 0; dcache_ram_valid = 0;

        // ---- writeback then refill, icache waiting throughout (last_d=0)
        icache_ram_valid = 1; icache_ram_addr = 32'h8000_0080;
        dcache_ram_valid = 1; dcache_ram_req = 1; dcache_ram_addr = 32'h8000_1200;
        dcache_ram_data_write = 64'hDEAD_BEEF_0000_0001;
        cyc(); settle();
        chk("wb.st",    64'(dut.state_q), 64'(ST_GD));
        chk("wb.req",   64'(arb_axi_req), 64'd1);
        chk("wb.addr",  64'(arb_axi_addr), 64'h8000_1200);
        chk("wb.wdata", arb_axi_data_write, 64'hDEAD_BEEF_0000_0001);
        axi_arb_ready = 1;
        settle();
        chk("wb.drdy", 64'(dcache_ram_ready), 64'd1);
        cyc();
        axi_arb_ready = 0;
        dcache_ram_req = 0; dcache_ram_addr = 32'h8000_2200; dcache_ram_data_write = 0;
        settle();
        chk("wb.hold",  64'(dut.state_q), 64'(ST_HOLD));
        chk("wb.gap",   64'(arb_axi_valid), 64'd0);
        cyc(); settle();
        chk("rf.st",    64'(dut.state_q), 64'(ST_GD));
        chk("rf.valid", 64'(arb_axi_valid), 64'd1);
        chk("rf.addr",  64'(arb_axi_addr), 64'h8000_2200);
        chk("rf.req",   64'(arb_axi_req), 64'd0);
        axi_arb_ready = 1;
        settle();
        chk("rf.drdy", 64'(dcache_ram_ready), 64'd1);
        chk("rf.irdy", 64'(icache_ram_ready), 64'd0);
        cyc();
        axi_arb_ready = 0; dcache_ram_valid = 0;
        settle();
        chk("rf.idle", 64'(dut.state_q), 64'(ST_IDLE));
        cyc(); settle();
        chk("rf.ignt", 64'(dut.state_q), 64'(ST_GI));
        chk("rf.iaddr", 64'(arb_axi_addr), 64'h8000_0080);
        axi_arb_ready = 1;
        cyc();
        axi_arb_ready = 0; icache_ram_valid = 0;

        // ---- flush gap: dcache drops valid in D_HOLD, icache waiting
        icache_ram_valid = 1; icache_ram_addr = 32'h8000_00C0;
        dcache_ram_valid = 1; dcache_ram_req = 1; dcache_ram_addr = 32'h8000_4400;
        dcache_ram_data_write = 64'h0123_4567_89AB_CDEF;
        cyc(); settle();
        chk("fl.st", 64'(dut.state_q), 64'(ST_GD));
        axi_arb_ready = 1;
        cyc();
        axi_arb_ready = 0; dcache_ram_valid = 0; dcache_ram_req = 0;
        settle();
        chk("fl.hold", 64'(dut.state_q), 64'(ST_HOLD));
        cyc(); settle();
        chk("fl.idle", 64'(dut.state_q), 64'(ST_IDLE));
        cyc(); settle();
        chk("fl.ignt", 64'(dut.state_q), 64'(ST_GI));
        chk("fl.iaddr", 64'(arb_axi_addr), 64'h8000_00C0);
        axi_arb_ready = 1;
        cyc();
        axi_arb_ready = 0; icache_ram_valid = 0;
        settle();

        // ---- spurious bridge ready in IDLE
        axi_arb_ready = 1; axi_arb_data_read = 64'h5555_5555_5555_5555;
        settle();
        chk("sp.rdy", 64'({icache_ram_ready, dcache_ram_ready}), 64'd0);
        cyc();
        axi_arb_ready = 0;
        settle();
        chk("sp.st",   64'(dut.state_q), 64'(ST_IDLE));
        chk("sp.busy", 64'(arb_busy), 64'd0);

        // ---- reset mid-grant (last_d made 1 first so its reset is visible)
        dcache_ram_valid = 1; dcache_ram_req = 0; dcache_ram_addr = 32'h8000_5000;
        cyc();
        axi_arb_ready = 1;
        cyc();
        axi_arb_ready = 0; dcache_ram_valid = 0;
        settle();
        chk("mr.last_d1", 64'(dut.last_d_q), 64'd1);
        icache_ram_valid = 1; icache_ram_addr = 32'h8000_0200;
        cyc(); settle();
        chk("mr.gnt", 64'(dut.state_q), 64'(ST_GI));
        rst = 1;
        cyc();
        rst = 0; icache_ram_valid = 0;
        axi_arb_ready = 1; axi_arb_data_read = 64'h7777_7777_7777_7777;
        settle();
        chk_idle_outs("mr");
        chk("mr.last_d", 64'(dut.last_d_q), 64'd0);
        cyc();
        axi_arb_ready = 0;
        settle();
        chk("mr.stay", 64'(dut.state_q), 64'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
